// File: rtl/usb_tx_pkg.sv
// Shared types and line-state constants for the USB transmit serializer.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StEopSe0,
        StEopJ
    } tx_state_t;

    // Bus symbols as {d_plus, d_minus}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam int unsigned STUFF_LEN_DEFAULT = 6;

endpackage

// File: rtl/usb_nrzi_encoder.sv
// NRZI line encoder: holds the current bus level and drives D+/D-.
module usb_nrzi_encoder
    import usb_tx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic bit_val_i,
    input  logic bit_en_i,
    input  logic force_se0_i,
    input  logic force_j_i,
    output logic d_plus_o,
    output logic d_minus_o
);

    logic [1:0] line_q, line_d;

    always_comb begin
        line_d = line_q;
        if (force_se0_i) begin
            line_d = LINE_SE0;
        end else if (force_j_i) begin
            line_d = LINE_J;
        end else if (bit_en_i && !bit_val_i) begin
            line_d = (line_q == LINE_J) ? LINE_K : LINE_J;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= LINE_J;
        end else begin
            line_q <= line_d;
        end
    end

    assign d_plus_o  = line_q[1];
    assign d_minus_o = line_q[0];

endmodule

// File: rtl/usb_tx_serializer.sv
// USB transmit serializer: one-entry holding register, LSB-first shifter with bit
// stuffing, NRZI encoding and EOP generation, paced by shift_strobe_i.
module usb_tx_serializer
    import usb_tx_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STUFF_LEN    = STUFF_LEN_DEFAULT,
    parameter int unsigned EOP_SE0_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift_strobe_i,
    input  logic [DATA_BITS-1:0] tx_data_i,
    input  logic                 tx_valid_i,
    input  logic                 tx_last_i,
    output logic                 tx_ready_o,
    output logic                 d_plus_o,
    output logic                 d_minus_o,
    output logic                 busy_o,
    output logic                 tx_err_o
);

    localparam int unsigned IdxW  = $clog2(DATA_BITS + 1);
    localparam int unsigned OnesW = $clog2(STUFF_LEN + 1);
    localparam int unsigned Se0W  = $clog2(EOP_SE0_BITS + 1);
    localparam logic [IdxW-1:0]  IdxEnd   = IdxW'(DATA_BITS);
    localparam logic [OnesW-1:0] OnesMax  = OnesW'(STUFF_LEN);
    localparam logic [Se0W-1:0]  Se0Max   = Se0W'(EOP_SE0_BITS);

    tx_state_t            state_q, state_d;
    logic                 hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
    logic                 hold_last_q, hold_last_d;
    logic                 last_seen_q, last_seen_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 cur_last_q, cur_last_d;
    logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
    logic [OnesW-1:0]     ones_q, ones_d;
    logic [Se0W-1:0]      se0_cnt_q, se0_cnt_d;
    logic                 err_q, err_d;

    logic load, send_next, bit_en, bit_val, force_se0, force_j;

    // Once the final byte is taken, no more bytes until the packet has fully ended
    assign tx_ready_o = !hold_full_q && !last_seen_q;
    assign busy_o     = (state_q != StIdle);
    assign tx_err_o   = err_q;

    always_comb begin
        state_d     = state_q;
        hold_full_d = hold_full_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        last_seen_d = last_seen_q;
        shift_d     = shift_q;
        cur_last_d  = cur_last_q;
        bit_idx_d   = bit_idx_q;
        ones_d      = ones_q;
        se0_cnt_d   = se0_cnt_q;
        err_d       = 1'b0;
        load        = 1'b0;
        send_next   = 1'b0;
        bit_en      = 1'b0;
        bit_val     = 1'b0;
        force_se0   = 1'b0;
        force_j     = 1'b0;

        if (tx_valid_i && tx_ready_o) begin
            hold_full_d = 1'b1;
            hold_data_d = tx_data_i;
            hold_last_d = tx_last_i;
            last_seen_d = tx_last_i;
        end

        if (shift_strobe_i) begin
            unique case (state_q)
                StIdle: load = hold_full_q;
                StShift: begin
                    // A pending stuff always goes out before the byte boundary
                    if (ones_q == OnesMax) begin
                        bit_en = 1'b1;
                        ones_d = '0;
                    end else if (bit_idx_q == IdxEnd) begin
                        if (!cur_last_q && hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            err_d     = !cur_last_q;
                            force_se0 = 1'b1;
                            se0_cnt_d = Se0W'(1);
                            state_d   = StEopSe0;
                        end
                    end else begin
                        send_next = 1'b1;
                    end
                end
                StEopSe0: begin
                    if (se0_cnt_q == Se0Max) begin
                        force_j = 1'b1;
                        state_d = StEopJ;
                    end else begin
                        force_se0 = 1'b1;
                        se0_cnt_d = se0_cnt_q + 1'b1;
                    end
                end
                StEopJ: begin
                    force_j     = 1'b1;
                    state_d     = StIdle;
                    bit_idx_d   = '0;
                    ones_d      = '0;
                    se0_cnt_d   = '0;
                    last_seen_d = 1'b0;
                end
                default: state_d = StIdle;
            endcase
        end

        if (load) begin
            bit_val     = hold_data_q[0];
            shift_d     = hold_data_q >> 1;
            cur_last_d  = hold_last_q;
            hold_full_d = 1'b0;
            bit_idx_d   = IdxW'(1);
            state_d     = StShift;
        end else if (send_next) begin
            bit_val   = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 1'b1;
        end

        if (load || send_next) begin
            bit_en = 1'b1;
            ones_d = bit_val ? ones_q + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            hold_full_q <= 1'b0;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            last_seen_q <= 1'b0;
            shift_q     <= '0;
            cur_last_q  <= 1'b0;
            bit_idx_q   <= '0;
            ones_q      <= '0;
            se0_cnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
            last_seen_q <= last_seen_d;
            shift_q     <= shift_d;
            cur_last_q  <= cur_last_d;
            bit_idx_q   <= bit_idx_d;
            ones_q      <= ones_d;
            se0_cnt_q   <= se0_cnt_d;
            err_q       <= err_d;
        end
    end

    usb_nrzi_encoder u_nrzi (
        .clk         (clk),
        .rst         (rst),
        .bit_val_i   (bit_val),
        .bit_en_i    (bit_en),
        .force_se0_i (force_se0),
        .force_j_i   (force_j),
        .d_plus_o    (d_plus_o),
        .d_minus_o   (d_minus_o)
    );

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Scoreboard bench for usb_tx_serializer: a packet-level model predicts the bus
// symbol seen after every strobe; a monitor compares what the DUT drives.
module tb_usb_tx_serializer;

    localparam logic [1:0] SymJ   = 2'b10;
    localparam logic [1:0] SymK   = 2'b01;
    localparam logic [1:0] SymSe0 = 2'b00;

    logic       clk = 1'b0;
    logic       rst;
    logic       shift_strobe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       d_plus;
    logic       d_minus;
    logic       busy;
    logic       tx_err;

    int n_tests = 0;
    int n_fail  = 0;
    int err_seen = 0;
    int popped   = 0;
    int rises    = 0;
    logic strobe_en = 1'b0;
    logic [1:0] sb_q[$];

    usb_tx_serializer dut (
        .clk            (clk),
        .rst            (rst),
        .shift_strobe_i (shift_strobe),
        .tx_data_i      (tx_data),
        .tx_valid_i     (tx_valid),
        .tx_last_i      (tx_last),
        .tx_ready_o     (tx_ready),
        .d_plus_o       (d_plus),
        .d_minus_o      (d_minus),
        .busy_o         (busy),
        .tx_err_o       (tx_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet model: LSB-first bits, a 0 after each run of six 1s, NRZI from J, then EOP
    task automatic build_expect(input logic [7:0] bytes[$]);
        bit         bits[$];
        int         run = 0;
        logic [1:0] lvl = SymJ;
        foreach (bytes[i]) begin
            for (int b = 0; b < 8; b++) begin
                bits.push_back(bytes[i][b]);
                run = bytes[i][b] ? run + 1 : 0;
                if (run == 6) begin
                    bits.push_back(1'b0);
                    run = 0;
                end
            end
        end
        foreach (bits[i]) begin
            if (!bits[i]) lvl = (lvl == SymJ) ? SymK : SymJ;
            sb_q.push_back(lvl);
        end
        sb_q.push_back(SymSe0);
        sb_q.push_back(SymSe0);
        sb_q.push_back(SymJ);
    endtask

    // Random strobes, never on two consecutive cycles
    initial begin
        shift_strobe = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            shift_strobe = strobe_en && !shift_strobe && ($urandom_range(0, 1) == 0);
        end
    end

    // Monitor: one expected symbol per strobe while a packet is in flight
    initial begin
        logic pre;
        forever begin
            @(negedge clk);
            if (shift_strobe && !rst) begin
                pre = busy;
                @(posedge clk);
                #1;
                if (!rst && busy) begin
                    if (sb_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_symbol: got %b expected none", {d_plus, d_minus});
                    end else begin
                        check("line_symbol", {30'd0, d_plus, d_minus}, {30'd0, sb_q.pop_front()});
                        popped++;
                    end
                end else if (!rst && pre) begin
                    check("idle_line_j", {30'd0, d_plus, d_minus}, {30'd0, SymJ});
                end
            end
        end
    end

    initial begin
        logic rdy_prev = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && tx_err) err_seen++;
            if (!rst && tx_ready && !rdy_prev) rises++;
            rdy_prev = tx_ready;
        end
    end

    task automatic send_pkt(input logic [7:0] bytes[$], input bit mark_last);
        int cyc;
        for (int i = 0; i < bytes.size(); i++) begin
            @(posedge clk);
            #2;
            tx_data  = bytes[i];
            tx_last  = mark_last && (i == bytes.size() - 1);
            tx_valid = 1'b1;
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!tx_ready && cyc < 2000);
            if (!tx_ready) check("accept_timeout", 32'd0, 32'd1);
        end
        @(posedge clk);
        #2;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while ((busy || sb_q.size() != 0) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 5000) begin
            check("idle_timeout", 32'd0, 32'd1);
            sb_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_pkt(input logic [7:0] bytes[$], input bit mark_last, input int exp_err,
                           input int exp_syms);
        int e0 = err_seen;
        int r0 = rises;
        int p0 = popped;
        if (mark_last) build_expect(bytes);
        else begin
            logic [7:0] one[$];
            one.push_back(bytes[0]);
            build_expect(one);
        end
        send_pkt(bytes, mark_last);
        wait_idle();
        check("tx_err_count", err_seen - e0, exp_err);
        check("ready_rises", rises - r0, bytes.size());
        if (exp_syms > 0) check("strobe_count", popped - p0, exp_syms);
        check("end_busy", {31'd0, busy}, 32'd0);
        check("end_ready", {31'd0, tx_ready}, 32'd1);
        check("end_line", {30'd0, d_plus, d_minus}, {30'd0, SymJ});
    endtask

    initial begin
        logic [7:0] pk[$];
        int p0;
        int cyc;
        rst = 1'b1;
        tx_valid = 1'b0;
        tx_last = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dplus", {31'd0, d_plus}, 32'd1);
        check("rst_dminus", {31'd0, d_minus}, 32'd0);
        check("rst_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, tx_err}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        strobe_en = 1'b1;
        repeat (10) @(posedge clk);
        check("no_start_when_empty", {31'd0, busy}, 32'd0);

        pk = '{8'h80};
        run_pkt(pk, 1'b1, 0, 11);
        pk = '{8'h80, 8'hFF};
        run_pkt(pk, 1'b1, 0, 20);
        pk = '{8'h80, 8'hFF, 8'hFF};
        run_pkt(pk, 1'b1, 0, 29);
        pk = '{8'h80};
        run_pkt(pk, 1'b0, 1, 11);

        for (int n = 0; n < 10; n++) begin
            int len = $urandom_range(1, 4);
            pk = '{8'h80};
            for (int i = 1; i < len; i++)
                pk.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            run_pkt(pk, 1'b1, 0, 0);
        end

        // Reset in the middle of the 3rd bit, then a clean packet
        pk = '{8'h80};
        p0 = popped;
        build_expect(pk);
        send_pkt(pk, 1'b1);
        cyc = 0;
        while (popped - p0 < 3 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_bit3", popped - p0, 3);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_dplus", {31'd0, d_plus}, 32'd1);
        check("midrst_dminus", {31'd0, d_minus}, 32'd0);
        check("midrst_ready", {31'd0, tx_ready}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        sb_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        pk = '{8'h80, 8'h3C, 8'hFE};
        run_pkt(pk, 1'b1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
